// File: rtl/cline_burst_adapter.sv
// cline_burst_adapter
// Takes one 256-bit cacheline read or write from the arbiter side and runs it
// as a four-beat, 64-bit burst on the physical-memory bus. Read beats are
// gathered into a line buffer. Write beats are served from a copy of the line
// captured at acceptance. A one-cycle line_resp closes each transaction.
// Every output is decoded from registered state, so no input reaches an
// output combinationally.

module cline_burst_adapter (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  line_address,
  output logic [255:0] line_rdata,
  input  logic [255:0] line_wdata,
  input  logic         line_read,
  input  logic         line_write,
  output logic         line_resp,
  output logic [31:0]  burst_address,
  input  logic [63:0]  burst_rdata,
  output logic [63:0]  burst_wdata,
  output logic         burst_read,
  output logic         burst_write,
  input  logic         burst_resp
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [1:0]     cnt;
  logic [31:0]    addr_q;
  logic [255:0]   wdata_q;
  logic [255:0]   line_buf;
  logic           last_beat;

  // The low five address bits select a byte inside the line, so the burst never uses them.
  logic           unused_offset_bits;
  assign unused_offset_bits = ^line_address[4:0];

  // The fourth accepted beat is the one taken while the counter reads 3.
  assign last_beat = burst_resp && (cnt == 2'd3);

  // State register. A synchronous reset abandons any burst in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus output decode. The outputs depend only on the
  // registered state, counter and latches.
  always_comb begin
    state_next  = state;
    line_resp   = 1'b0;
    burst_read  = 1'b0;
    burst_write = 1'b0;
    burst_wdata = 64'd0;
    case (state)
      IDLE: begin
        if (line_write) begin
          state_next = WR;
        end else if (line_read) begin
          state_next = RD;
        end
      end
      RD: begin
        burst_read = 1'b1;
        if (last_beat) begin
          state_next = RESP;
        end
      end
      WR: begin
        burst_write = 1'b1;
        burst_wdata = wdata_q[{cnt, 6'b000000} +: 64];
        if (last_beat) begin
          state_next = RESP;
        end
      end
      RESP: begin
        line_resp  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath. It captures the request at acceptance, counts beats, and fills
  // the read buffer slot by slot. Beats that arrive outside RD and WR are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 2'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 256'd0;
      line_buf <= 256'd0;
    end else begin
      case (state)
        IDLE: begin
          if (line_write) begin
            addr_q  <= {line_address[31:5], 5'b00000};
            wdata_q <= line_wdata;
            cnt     <= 2'd0;
          end else if (line_read) begin
            addr_q  <= {line_address[31:5], 5'b00000};
            cnt     <= 2'd0;
          end
        end
        RD: begin
          if (burst_resp) begin
            line_buf[{cnt, 6'b000000} +: 64] <= burst_rdata;
            cnt                              <= cnt + 2'd1;
          end
        end
        WR: begin
          if (burst_resp) begin
            cnt <= cnt + 2'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign burst_address = addr_q;
  assign line_rdata    = line_buf;

endmodule

// File: tb/tb_cline_burst_adapter.sv
// tb_cline_burst_adapter
// Directed bench for cline_burst_adapter. A transaction-level model tracks
// whether a line is in flight, how many beats have completed, and the line
// contents. A per-cycle compare process checks the DUT against that model.
// Hand-computed literal checks at key cycles pin the model to the expected behaviour.

module tb_cline_burst_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  line_address;
  logic [255:0] line_rdata;
  logic [255:0] line_wdata;
  logic         line_read;
  logic         line_write;
  logic         line_resp;
  logic [31:0]  burst_address;
  logic [63:0]  burst_rdata;
  logic [63:0]  burst_wdata;
  logic         burst_read;
  logic         burst_write;
  logic         burst_resp;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  // Transaction-level model state.
  bit           m_busy;
  bit           m_is_write;
  bit           m_resp;
  int           m_beats;
  logic [31:0]  m_addr;
  logic [255:0] m_wline;
  logic [255:0] m_buf;

  localparam logic [63:0] D0 = 64'hD0D0_0000_0000_D0D0;
  localparam logic [63:0] D1 = 64'hD1D1_1111_1111_D1D1;
  localparam logic [63:0] D2 = 64'hD2D2_2222_2222_D2D2;
  localparam logic [63:0] D3 = 64'hD3D3_3333_3333_D3D3;
  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

  cline_burst_adapter dut (
    .clk           (clk),
    .rst           (rst),
    .line_address  (line_address),
    .line_rdata    (line_rdata),
    .line_wdata    (line_wdata),
    .line_read     (line_read),
    .line_write    (line_write),
    .line_resp     (line_resp),
    .burst_address (burst_address),
    .burst_rdata   (burst_rdata),
    .burst_wdata   (burst_wdata),
    .burst_read    (burst_read),
    .burst_write   (burst_write),
    .burst_resp    (burst_resp)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [255:0] actual, input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and hold them across the next rising edge.
  task automatic apply_stimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [255:0] wd, input logic br, input logic [63:0] brd);
    line_read    = rd;
    line_write   = wr;
    line_address = addr;
    line_wdata   = wd;
    burst_resp   = br;
    burst_rdata  = brd;
    if (rd && wr && !m_busy && !m_resp)
      $display("[TB] note: line_read and line_write both high in IDLE (illegal stimulus, write takes priority)");
    @(negedge clk);
  endtask

  // Model: one line in flight at a time. Four accepted beats end it, then one completion cycle follows.
  always @(posedge clk) begin
    if (rst) begin
      m_busy     <= 1'b0;
      m_is_write <= 1'b0;
      m_resp     <= 1'b0;
      m_beats    <= 0;
      m_addr     <= 32'd0;
      m_wline    <= 256'd0;
      m_buf      <= 256'd0;
    end else if (m_resp) begin
      m_resp <= 1'b0;
    end else if (!m_busy) begin
      if (line_write || line_read) begin
        m_busy     <= 1'b1;
        m_is_write <= line_write;
        m_beats    <= 0;
        m_addr     <= line_address & 32'hFFFF_FFE0;
        if (line_write) m_wline <= line_wdata;
      end
    end else if (burst_resp) begin
      if (!m_is_write) m_buf[m_beats*64 +: 64] <= burst_rdata;
      m_beats <= m_beats + 1;
      if (m_beats == 3) begin
        m_busy <= 1'b0;
        m_resp <= 1'b1;
      end
    end
  end

  // Per-cycle comparison of all outputs against the model, taken on the falling edge.
  always @(negedge clk) begin
    if (check_en) begin
      check_output("line_resp", {255'd0, line_resp}, {255'd0, m_resp});
      check_output("burst_read", {255'd0, burst_read}, {255'd0, m_busy && !m_is_write});
      check_output("burst_write", {255'd0, burst_write}, {255'd0, m_busy && m_is_write});
      check_output("burst_address", {224'd0, burst_address}, {224'd0, m_addr});
      check_output("line_rdata", line_rdata, m_buf);
      if (m_busy && m_is_write)
        check_output("burst_wdata", {192'd0, burst_wdata}, {192'd0, m_wline[m_beats*64 +: 64]});
    end
  end

  initial begin
    logic [63:0]  beat_data;
    logic [63:0]  exp_wd;
    logic [255:0] wline;
    bit           br;

    rst = 1'b1;
    line_read = 1'b0; line_write = 1'b0; line_address = 32'd0; line_wdata = 256'd0;
    burst_resp = 1'b0; burst_rdata = 64'd0;
    @(negedge clk);
    check_en = 1'b1;
    check_output("reset_line_resp", {255'd0, line_resp}, 256'd0);
    check_output("reset_burst_read", {255'd0, burst_read}, 256'd0);
    check_output("reset_burst_write", {255'd0, burst_write}, 256'd0);
    check_output("reset_burst_address", {224'd0, burst_address}, 256'd0);
    check_output("reset_burst_wdata", {192'd0, burst_wdata}, 256'd0);
    check_output("reset_line_rdata", line_rdata, 256'd0);
    apply_stimulus(0, 0, 32'd0, 256'd0, 0, 64'd0);
    rst = 1'b0;
    apply_stimulus(0, 0, 32'd0, 256'd0, 0, 64'd0);

    // Read with no stalls: beats in cycles 1-4, response in cycle 5.
    for (int c = 0; c <= 6; c++) begin
      if (c == 1) check_output("rd_addr", {224'd0, burst_address}, {224'd0, 32'h0000_1220});
      if (c == 4) check_output("rd_no_resp_early", {255'd0, line_resp}, 256'd0);
      if (c == 5) begin
        check_output("rd_resp", {255'd0, line_resp}, 256'd1);
        check_output("rd_line", line_rdata, {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}});
      end
      if (c == 6) check_output("rd_back_idle", {254'd0, line_resp, burst_read}, 256'd0);
      br = (c >= 1 && c <= 4);
      beat_data = br ? {4{c[3:0], c[3:0], c[3:0], c[3:0]}} : 64'd0;
      apply_stimulus(c <= 5, 0, 32'h0000_1234, 256'd0, br, beat_data);
    end

    // Write with stalls: beats in cycles 2, 5, 6 and 9. Line inputs are scrambled after acceptance.
    wline = {D3, D2, D1, D0};
    for (int c = 0; c <= 11; c++) begin
      exp_wd = (c <= 2) ? D0 : (c <= 5) ? D1 : (c == 6) ? D2 : D3;
      if (c >= 1 && c <= 9) check_output("wr_wdata", {192'd0, burst_wdata}, {192'd0, exp_wd});
      if (c == 1) check_output("wr_addr", {224'd0, burst_address}, {224'd0, 32'hABCD_EF00});
      if (c == 9) check_output("wr_no_resp_early", {255'd0, line_resp}, 256'd0);
      if (c == 10) check_output("wr_resp", {254'd0, line_resp, burst_write}, 256'd2);
      br = (c == 2 || c == 5 || c == 6 || c == 9);
      apply_stimulus(0, c <= 10, (c == 0) ? 32'hABCD_EF1F : 32'hFFFF_FFFF,
                     (c == 0) ? wline : ~wline, br, JUNK);
    end

    // Simultaneous request: the write wins, then the read that is still held starts a new burst.
    for (int c = 0; c <= 12; c++) begin
      if (c == 1) check_output("sim_write_only", {254'd0, burst_read, burst_write}, 256'd1);
      if (c == 5) check_output("sim_wr_resp", {255'd0, line_resp}, 256'd1);
      if (c == 7) check_output("sim_read_next", {254'd0, burst_read, burst_write}, 256'd2);
      if (c == 11) check_output("sim_rd_line", line_rdata,
                                {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
                                 64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0});
      br = (c >= 1 && c <= 4) || (c >= 7 && c <= 10);
      beat_data = (c >= 7) ? {8{4'hA, c[3:0] - 4'd7}} : JUNK;
      apply_stimulus(c <= 11, c <= 5, 32'h0000_0100, {D0, D1, D2, D3}, br, beat_data);
    end

    // Reset during a read after two beats: strobes drop and no response follows.
    for (int c = 0; c <= 8; c++) begin
      if (c == 3) check_output("rst_rd_active", {255'd0, burst_read}, 256'd1);
      if (c == 4) begin
        check_output("rst_rd_dropped", {255'd0, burst_read}, 256'd0);
        check_output("rst_buf_cleared", line_rdata, 256'd0);
      end
      rst = (c == 3);
      br = (c == 1 || c == 2);
      apply_stimulus(c <= 2, 0, 32'h0000_2000, 256'd0, br, {4{16'h5566}});
    end
    rst = 1'b0;
    for (int c = 0; c <= 6; c++) begin
      if (c == 5) check_output("rst_followup_line", line_rdata,
                               {{4{16'hAAAA}}, {4{16'h9999}}, {4{16'h8888}}, {4{16'h7777}}});
      br = (c >= 1 && c <= 4);
      beat_data = (c == 1) ? {4{16'h7777}} : (c == 2) ? {4{16'h8888}} :
                  (c == 3) ? {4{16'h9999}} : {4{16'hAAAA}};
      apply_stimulus(c <= 4, 0, 32'h0000_3000, 256'd0, br, beat_data);
    end

    // Spurious beats in IDLE, including the acceptance cycle, and during RESP are ignored.
    for (int c = 0; c <= 9; c++) begin
      if (c == 3) check_output("spur_idle_buf", line_rdata,
                               {{4{16'hAAAA}}, {4{16'h9999}}, {4{16'h8888}}, {4{16'h7777}}});
      if (c == 9) check_output("spur_line", line_rdata,
                               {{8{8'h04}}, {8{8'h03}}, {8{8'h02}}, {8{8'h01}}});
      br = (c <= 8);
      beat_data = (c >= 4 && c <= 7) ? {8{4'h0, c[3:0] - 4'd3}} : JUNK;
      apply_stimulus(c >= 3 && c <= 7, 0, 32'h0000_4000, 256'd0, br, beat_data);
    end

    // Back-to-back reads: the first line holds until beat 0 of the second read.
    for (int c = 0; c <= 14; c++) begin
      if (c == 7) check_output("b2b_addr2", {224'd0, burst_address}, {224'd0, 32'h0000_8060});
      if (c == 9) check_output("b2b_hold", line_rdata, {{4{16'hA3A3}}, {4{16'hA2A2}}, {4{16'hA1A1}}, {4{16'hA0A0}}});
      if (c == 10) check_output("b2b_slot0", line_rdata, {{4{16'hA3A3}}, {4{16'hA2A2}}, {4{16'hA1A1}}, {4{16'hB0B0}}});
      if (c == 13) check_output("b2b_line2", line_rdata, {{4{16'hB3B3}}, {4{16'hB2B2}}, {4{16'hB1B1}}, {4{16'hB0B0}}});
      br = (c >= 1 && c <= 4) || (c >= 9 && c <= 12);
      beat_data = (c <= 4) ? {16{4'hA, c[3:0] - 4'd1}} >> 0 : {16{4'hB, c[3:0] - 4'd9}};
      beat_data = (c <= 4) ? {8{4'hA, c[3:0] - 4'd1}} : {8{4'hB, c[3:0] - 4'd9}};
      apply_stimulus(c <= 12, 0, (c <= 5) ? 32'h0000_4040 : 32'h0000_8060, 256'd0, br, beat_data);
    end

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
